// File: rtl/ps2_scancode_decoder_if.sv
// ps2_scancode_decoder_if
// Bundles the byte input from the PS/2 receiver, the decoded-event stream
// toward the consumer and the live status outputs of the decoder.
//   RX_DATA / RX_VALID : byte and one-cycle qualifier from the PS/2 receiver
//   EV_*               : head of the event FIFO (valid/ready handshake)
//   MODS               : live modifier state
//   OVERFLOW           : sticky event-dropped flag
// The decoder connects through the slave modport; the byte source and
// event consumer use the master modport.
interface ps2_scancode_decoder_if;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic [7:0] EV_CODE;
    logic       EV_EXT;
    logic       EV_BREAK;
    logic [5:0] EV_MODS;
    logic       EV_VALID;
    logic       EV_READY;
    logic [5:0] MODS;
    logic       OVERFLOW;

    modport master (
        output RX_DATA, RX_VALID, EV_READY,
        input  EV_CODE, EV_EXT, EV_BREAK, EV_MODS, EV_VALID, MODS, OVERFLOW
    );

    modport slave (
        input  RX_DATA, RX_VALID, EV_READY,
        output EV_CODE, EV_EXT, EV_BREAK, EV_MODS, EV_VALID, MODS, OVERFLOW
    );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
// Turns the raw byte stream of a PS/2 keyboard (scan code set 2) into key
// events. E0 and F0 prefixes are folded into ext/break flags, a live modifier
// mask is kept for the shift/ctrl/alt keys, and every completed event is
// queued with a snapshot of that mask in a first-word-fall-through FIFO.
//
// Ports
//   CLK   : system clock, rising edge
//   RST   : synchronous active-high reset
//   bus   : ps2_scancode_decoder_if.slave
//           RX_DATA/RX_VALID in, EV_* handshake out/in, MODS, OVERFLOW out
//
// Prefix FSM
//   state     | meaning
//   IDLE      | no prefix pending
//   GOT_E0    | E0 seen, waiting for code or F0
//   GOT_F0    | F0 seen, waiting for code
//   GOT_E0F0  | E0 F0 seen, waiting for code
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    ps2_scancode_decoder_if.slave bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GOT_E0   = 2'd1,
        GOT_F0   = 2'd2,
        GOT_E0F0 = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [5:0] mods;
    } ev_t;

    state_t             state_q;
    logic [5:0]         mods_q;
    logic               ovf_q;
    logic [CNT_W-1:0]   count_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    ev_t                head_q;
    ev_t                mem [FIFO_DEPTH];

    logic               is_e0;
    logic               is_f0;
    logic               is_noise;
    logic               complete;
    logic               seq_ext;
    logic               seq_brk;
    logic [5:0]         mod_sel;
    logic [5:0]         mods_n;
    ev_t                new_ev;
    logic               pop;
    logic               full;
    logic               push_ok;
    logic [PTR_W-1:0]   wr_ptr_n;
    logic [PTR_W-1:0]   rd_ptr_n;
    logic [CNT_W-1:0]   count_n;
    ev_t                head_n;

    always_comb begin
        is_e0    = (bus.RX_DATA == 8'hE0);
        is_f0    = (bus.RX_DATA == 8'hF0);
        is_noise = 1'b0;
        case (bus.RX_DATA)
            8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_noise = 1'b1;
            default:                                                is_noise = 1'b0;
        endcase

        seq_ext  = (state_q == GOT_E0) || (state_q == GOT_E0F0);
        seq_brk  = (state_q == GOT_F0) || (state_q == GOT_E0F0);

        // Controller responses (ACK, BAT result, ...) only count as noise
        // outside a prefixed sequence.
        complete = bus.RX_VALID && !is_e0 && !is_f0 &&
                   !((state_q == IDLE) && is_noise);

        // E0 12 / E0 59 are the fake shifts some keys emit; they map to no bit.
        mod_sel = 6'b000000;
        case (bus.RX_DATA)
            8'h12:   mod_sel = seq_ext ? 6'b000000 : 6'b000001;
            8'h59:   mod_sel = seq_ext ? 6'b000000 : 6'b000010;
            8'h14:   mod_sel = seq_ext ? 6'b001000 : 6'b000100;
            8'h11:   mod_sel = seq_ext ? 6'b100000 : 6'b010000;
            default: mod_sel = 6'b000000;
        endcase

        mods_n = mods_q;
        if (complete) begin
            mods_n = seq_brk ? (mods_q & ~mod_sel) : (mods_q | mod_sel);
        end

        new_ev.code = bus.RX_DATA;
        new_ev.ext  = seq_ext;
        new_ev.brk  = seq_brk;
        new_ev.mods = mods_n;

        pop     = (count_q != '0) && bus.EV_READY;
        full    = (count_q == CNT_W'(FIFO_DEPTH));
        push_ok = complete && (!full || pop);

        wr_ptr_n = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_n = pop     ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_n = count_q;
        case ({push_ok, pop})
            2'b10:   count_n = count_q + CNT_W'(1);
            2'b01:   count_n = count_q - CNT_W'(1);
            default: count_n = count_q;
        endcase

        // The head register tracks the entry at the next read pointer. If
        // that slot is the one being written this cycle, take the incoming
        // event directly; when the FIFO drains, keep the last head.
        head_n = head_q;
        if (count_n != '0) begin
            if (push_ok && (wr_ptr_q == rd_ptr_n)) begin
                head_n = new_ev;
            end else begin
                head_n = mem[rd_ptr_n];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            mods_q   <= 6'b000000;
            ovf_q    <= 1'b0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
        end else begin
            if (bus.RX_VALID) begin
                if (is_e0) begin
                    state_q <= GOT_E0;
                end else if (is_f0) begin
                    case (state_q)
                        IDLE:    state_q <= GOT_F0;
                        GOT_E0:  state_q <= GOT_E0F0;
                        default: state_q <= state_q;
                    endcase
                end else begin
                    state_q <= IDLE;
                end
            end
            mods_q   <= mods_n;
            if (complete && !push_ok) begin
                ovf_q <= 1'b1;
            end
            count_q  <= count_n;
            wr_ptr_q <= wr_ptr_n;
            rd_ptr_q <= rd_ptr_n;
            head_q   <= head_n;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && push_ok) begin
            mem[wr_ptr_q] <= new_ev;
        end
    end

    assign bus.EV_CODE  = head_q.code;
    assign bus.EV_EXT   = head_q.ext;
    assign bus.EV_BREAK = head_q.brk;
    assign bus.EV_MODS  = head_q.mods;
    assign bus.EV_VALID = (count_q != '0);
    assign bus.MODS     = mods_q;
    assign bus.OVERFLOW = ovf_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: directed scenarios with fixed expected
// events plus a randomized byte stream checked against a queue-based model.
module tb_ps2_scancode_decoder;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ps2_scancode_decoder_if bus ();

    ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: pending-prefix flags, modifier mask, sticky overflow,
    // and a queue of {code, ext, brk, mods} events.
    logic [15:0] mq [$];
    bit          m_e0;
    bit          m_f0;
    logic [5:0]  m_mods;
    bit          m_ovf;

    logic [7:0] noise_tab [8] = '{8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
    logic [7:0] mod_tab   [4] = '{8'h12, 8'h59, 8'h14, 8'h11};

    function automatic bit is_noise(input logic [7:0] d);
        foreach (noise_tab[i]) if (noise_tab[i] == d) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int mod_bit(input bit ext, input logic [7:0] c);
        if (!ext && c == 8'h12) return 0;
        if (!ext && c == 8'h59) return 1;
        if (!ext && c == 8'h14) return 2;
        if ( ext && c == 8'h14) return 3;
        if (!ext && c == 8'h11) return 4;
        if ( ext && c == 8'h11) return 5;
        return -1;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_e0 = 0; m_f0 = 0; m_mods = '0; m_ovf = 0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic rdy);
        int b;
        if (rdy && mq.size() > 0) void'(mq.pop_front());
        if (v) begin
            if (d == 8'hE0) begin
                m_e0 = 1; m_f0 = 0;
            end else if (d == 8'hF0) begin
                m_f0 = 1;
            end else if (!m_e0 && !m_f0 && is_noise(d)) begin
                // controller response, ignored
            end else begin
                b = mod_bit(m_e0, d);
                if (b >= 0) m_mods[b] = !m_f0;
                if (mq.size() < DEPTH) mq.push_back({d, m_e0, m_f0, m_mods});
                else m_ovf = 1;
                m_e0 = 0; m_f0 = 0;
            end
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic rdy);
        bus.RX_VALID = v;
        bus.RX_DATA  = d;
        bus.EV_READY = rdy;
        model_step(v, d, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic v, input logic [7:0] d);
        rst = 1'b1;
        bus.RX_VALID = v;
        bus.RX_DATA  = d;
        bus.EV_READY = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.RX_VALID = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset(1'b0, 8'h00);
        n_checks++;
        if ({bus.EV_VALID, bus.MODS, bus.OVERFLOW, bus.EV_CODE, bus.EV_EXT, bus.EV_BREAK, bus.EV_MODS} !== 24'h0)
            $display("FAIL reset_initial: got valid=%b mods=%h ovf=%b code=%h ext=%b brk=%b evmods=%h, want all zero",
                     bus.EV_VALID, bus.MODS, bus.OVERFLOW, bus.EV_CODE, bus.EV_EXT, bus.EV_BREAK, bus.EV_MODS);
        else n_pass++;
        drive(1'b1, 8'h12, 1'b0);
        drive(1'b1, 8'h1C, 1'b0);
        do_reset(1'b1, 8'h5A);
        n_checks++;
        if ({bus.EV_VALID, bus.MODS, bus.OVERFLOW, bus.EV_CODE, bus.EV_EXT, bus.EV_BREAK, bus.EV_MODS} !== 24'h0)
            $display("FAIL reset_busy: got valid=%b mods=%h ovf=%b code=%h ext=%b brk=%b evmods=%h, want all zero",
                     bus.EV_VALID, bus.MODS, bus.OVERFLOW, bus.EV_CODE, bus.EV_EXT, bus.EV_BREAK, bus.EV_MODS);
        else n_pass++;
    endtask

    task automatic test_ralt_chord();
        logic [7:0]  seq [8] = '{8'hE0, 8'h11, 8'h1C, 8'hF0, 8'h1C, 8'hE0, 8'hF0, 8'h11};
        logic [15:0] exp_ev [4] = '{{8'h11, 1'b1, 1'b0, 6'h20}, {8'h1C, 1'b0, 1'b0, 6'h20},
                                    {8'h1C, 1'b0, 1'b1, 6'h20}, {8'h11, 1'b1, 1'b1, 6'h00}};
        int k = 0;
        do_reset(1'b0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, seq[i], 1'b1);
            if (seq[i] != 8'hE0 && seq[i] != 8'hF0) begin
                n_checks++;
                if ({bus.EV_VALID, bus.EV_CODE, bus.EV_EXT, bus.EV_BREAK, bus.EV_MODS} !== {1'b1, exp_ev[k]})
                    $display("FAIL ralt_ev%0d: got valid=%b ev=%h, want valid=1 ev=%h", k,
                             bus.EV_VALID, {bus.EV_CODE, bus.EV_EXT, bus.EV_BREAK, bus.EV_MODS}, exp_ev[k]);
                else n_pass++;
                k++;
            end
        end
        drive(1'b0, 8'h00, 1'b1);
        n_checks++;
        if ({bus.EV_VALID, bus.MODS} !== 7'h00)
            $display("FAIL ralt_end: got valid=%b mods=%h, want valid=0 mods=00", bus.EV_VALID, bus.MODS);
        else n_pass++;
    endtask

    task automatic test_enter();
        do_reset(1'b0, 8'h00);
        drive(1'b1, 8'h5A, 1'b1);
        n_checks++;
        if ({bus.EV_VALID, bus.EV_CODE, bus.EV_EXT, bus.EV_BREAK, bus.EV_MODS} !== {1'b1, 8'h5A, 1'b0, 1'b0, 6'h00})
            $display("FAIL enter_make: got valid=%b code=%h ext=%b brk=%b mods=%h, want 1 5a 0 0 00",
                     bus.EV_VALID, bus.EV_CODE, bus.EV_EXT, bus.EV_BREAK, bus.EV_MODS);
        else n_pass++;
        drive(1'b1, 8'hF0, 1'b1);
        n_checks++;
        if (bus.EV_VALID !== 1'b0)
            $display("FAIL enter_gap: got valid=%b, want 0", bus.EV_VALID);
        else n_pass++;
        drive(1'b1, 8'h5A, 1'b1);
        n_checks++;
        if ({bus.EV_VALID, bus.EV_CODE, bus.EV_EXT, bus.EV_BREAK, bus.EV_MODS} !== {1'b1, 8'h5A, 1'b0, 1'b1, 6'h00})
            $display("FAIL enter_break: got valid=%b code=%h ext=%b brk=%b mods=%h, want 1 5a 0 1 00",
                     bus.EV_VALID, bus.EV_CODE, bus.EV_EXT, bus.EV_BREAK, bus.EV_MODS);
        else n_pass++;
        drive(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_overflow();
        logic [7:0] makes [5] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34};
        do_reset(1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, makes[i], 1'b0);
            if (i >= 3) begin
                n_checks++;
                if ({bus.EV_VALID, bus.OVERFLOW} !== {1'b1, (i == 4) ? 1'b1 : 1'b0})
                    $display("FAIL ovf_fill%0d: got valid=%b ovf=%b, want valid=1 ovf=%b", i,
                             bus.EV_VALID, bus.OVERFLOW, (i == 4));
                else n_pass++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({bus.EV_VALID, bus.EV_CODE, bus.EV_EXT, bus.EV_BREAK, bus.EV_MODS} !== {1'b1, makes[i], 8'h00})
                $display("FAIL ovf_drain%0d: got valid=%b code=%h, want valid=1 code=%h", i,
                         bus.EV_VALID, bus.EV_CODE, makes[i]);
            else n_pass++;
            drive(1'b0, 8'h00, 1'b1);
        end
        n_checks++;
        if ({bus.EV_VALID, bus.OVERFLOW} !== 2'b01)
            $display("FAIL ovf_end: got valid=%b ovf=%b, want valid=0 ovf=1", bus.EV_VALID, bus.OVERFLOW);
        else n_pass++;
    endtask

    task automatic test_full_simul();
        logic [7:0] codes [5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h3C};
        do_reset(1'b0, 8'h00);
        for (int i = 0; i < 4; i++) drive(1'b1, codes[i], 1'b0);
        drive(1'b1, codes[4], 1'b1);
        n_checks++;
        if (bus.OVERFLOW !== 1'b0)
            $display("FAIL full_simul_ovf: got ovf=%b, want 0", bus.OVERFLOW);
        else n_pass++;
        for (int i = 1; i < 5; i++) begin
            n_checks++;
            if ({bus.EV_VALID, bus.EV_CODE} !== {1'b1, codes[i]})
                $display("FAIL full_simul_drain%0d: got valid=%b code=%h, want valid=1 code=%h", i,
                         bus.EV_VALID, bus.EV_CODE, codes[i]);
            else n_pass++;
            drive(1'b0, 8'h00, 1'b1);
        end
        n_checks++;
        if ({bus.EV_VALID, bus.OVERFLOW} !== 2'b00)
            $display("FAIL full_simul_end: got valid=%b ovf=%b, want 0 0", bus.EV_VALID, bus.OVERFLOW);
        else n_pass++;
    endtask

    task automatic test_noise_abort();
        do_reset(1'b0, 8'h00);
        drive(1'b1, 8'hAA, 1'b1);
        drive(1'b1, 8'hFA, 1'b1);
        n_checks++;
        if (bus.EV_VALID !== 1'b0)
            $display("FAIL noise_discard: got valid=%b, want 0", bus.EV_VALID);
        else n_pass++;
        drive(1'b1, 8'hE0, 1'b1);
        drive(1'b1, 8'hF0, 1'b1);
        drive(1'b1, 8'hE0, 1'b1);
        drive(1'b1, 8'h75, 1'b1);
        n_checks++;
        if ({bus.EV_VALID, bus.EV_CODE, bus.EV_EXT, bus.EV_BREAK} !== {1'b1, 8'h75, 1'b1, 1'b0})
            $display("FAIL abort_ev: got valid=%b code=%h ext=%b brk=%b, want 1 75 1 0",
                     bus.EV_VALID, bus.EV_CODE, bus.EV_EXT, bus.EV_BREAK);
        else n_pass++;
        drive(1'b0, 8'h00, 1'b1);
        n_checks++;
        if (bus.EV_VALID !== 1'b0)
            $display("FAIL abort_single: got valid=%b, want 0", bus.EV_VALID);
        else n_pass++;
        drive(1'b1, 8'h12, 1'b1);
        n_checks++;
        if ({bus.MODS, bus.EV_VALID, bus.EV_CODE, bus.EV_MODS} !== {6'h01, 1'b1, 8'h12, 6'h01})
            $display("FAIL lshift_make: got mods=%h valid=%b code=%h evmods=%h, want 01 1 12 01",
                     bus.MODS, bus.EV_VALID, bus.EV_CODE, bus.EV_MODS);
        else n_pass++;
        drive(1'b1, 8'hF0, 1'b1);
        do_reset(1'b1, 8'h12);
        n_checks++;
        if ({bus.MODS, bus.EV_VALID} !== 7'h00)
            $display("FAIL rst_mid_seq: got mods=%h valid=%b, want 00 0", bus.MODS, bus.EV_VALID);
        else n_pass++;
        drive(1'b1, 8'h1C, 1'b1);
        n_checks++;
        if ({bus.EV_VALID, bus.EV_CODE, bus.EV_EXT, bus.EV_BREAK, bus.EV_MODS} !== {1'b1, 8'h1C, 1'b0, 1'b0, 6'h00})
            $display("FAIL after_rst_ev: got valid=%b code=%h ext=%b brk=%b mods=%h, want 1 1c 0 0 00",
                     bus.EV_VALID, bus.EV_CODE, bus.EV_EXT, bus.EV_BREAK, bus.EV_MODS);
        else n_pass++;
        drive(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_random();
        logic        v;
        logic        rdy;
        logic [7:0]  d;
        logic [15:0] exp_head;
        int          sel;
        for (int r = 0; r < 4; r++) begin
            do_reset(1'b0, 8'h00);
            for (int c = 0; c < 400; c++) begin
                v   = ($urandom_range(0, 9) < 7);
                rdy = ($urandom_range(0, 3) < ((r % 2 == 0) ? 3 : 1));
                sel = $urandom_range(0, 9);
                if (sel < 2)       d = 8'hE0;
                else if (sel == 2) d = 8'hF0;
                else if (sel == 3) d = noise_tab[$urandom_range(0, 7)];
                else if (sel < 6)  d = mod_tab[$urandom_range(0, 3)];
                else               d = 8'($urandom_range(0, 255));
                drive(v, d, rdy);
                exp_head = (mq.size() > 0) ? mq[0] : 16'h0;
                n_checks++;
                if (bus.EV_VALID !== (mq.size() > 0) || bus.MODS !== m_mods || bus.OVERFLOW !== m_ovf ||
                    (mq.size() > 0 && {bus.EV_CODE, bus.EV_EXT, bus.EV_BREAK, bus.EV_MODS} !== exp_head))
                    $display("FAIL random r%0d c%0d: got valid=%b ev=%h mods=%h ovf=%b, want valid=%b ev=%h mods=%h ovf=%b",
                             r, c, bus.EV_VALID, {bus.EV_CODE, bus.EV_EXT, bus.EV_BREAK, bus.EV_MODS},
                             bus.MODS, bus.OVERFLOW, (mq.size() > 0), exp_head, m_mods, m_ovf);
                else n_pass++;
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.RX_VALID = 1'b0;
        bus.RX_DATA  = 8'h00;
        bus.EV_READY = 1'b0;
        model_reset();
        test_reset();
        test_ralt_chord();
        test_enter();
        test_overflow();
        test_full_simul();
        test_noise_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
